// File: rtl/databus_burst_reader_pkg.sv
// Shared constants, beat-size helpers and FSM state type for the databus burst reader.
package databus_burst_reader_pkg;

  localparam int unsigned BOUNDARY_BYTES = 4096;
  localparam int unsigned BOUNDARY_W     = $clog2(BOUNDARY_BYTES);

  function automatic int unsigned bytes_per_beat(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned log2_bytes_per_beat(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAN,
    ST_REQ,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/databus_burst_reader_burst_fifo.sv
// Beat FIFO storing data plus a transfer-last tag; exposes occupancy and a synchronous flush.
module burst_fifo
  import databus_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_last,
  input  logic                         i_pop,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_last,
  output logic                         o_empty,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_pop;

  // Producer reserves space before pushing, so only the pop side needs guarding.
  assign w_pop   = i_pop & (r_count != '0);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign {o_last, o_data} = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= {i_last, i_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/databus_burst_reader.sv
// Row-strided read engine: splits rows into databus bursts (MAX_BURST / 4 KiB / FIFO credit)
// and streams returned beats to the local-memory writer.
module databus_burst_reader
  import databus_burst_reader_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned COUNT_W    = 17,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_i,
  input  logic                  running_i,
  output logic                  done_o,
  input  logic [AXI_ADDR_W-1:0] ext_addr_i,
  input  logic [COUNT_W-1:0]    read_amount_minus_one_i,
  input  logic [LEN_W-1:0]      read_length_i,
  input  logic [AXI_ADDR_W-1:0] read_addr_shift_i,
  output logic                  databus_valid_o,
  output logic [AXI_ADDR_W-1:0] databus_addr_o,
  output logic [LEN_W-1:0]      databus_len_o,
  input  logic                  databus_ready_i,
  input  logic [AXI_DATA_W-1:0] databus_rdata_i,
  input  logic                  databus_last_i,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic [AXI_DATA_W-1:0] data_o,
  output logic                  data_last_o
);

  localparam int unsigned BPB       = bytes_per_beat(AXI_DATA_W);
  localparam int unsigned LOG2_BPB  = log2_bytes_per_beat(AXI_DATA_W);
  localparam int unsigned MAX_BYTES = MAX_BURST * BPB;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ROWS_W    = COUNT_W + 1;

  state_t                r_state;
  logic [ROWS_W-1:0]     r_rows;
  logic [AXI_ADDR_W-1:0] r_row_base;
  logic [AXI_ADDR_W-1:0] r_cur_addr;
  logic [AXI_ADDR_W-1:0] r_shift;
  logic [LEN_W-1:0]      r_row_rem;
  logic [LEN_W-1:0]      r_length;
  logic [CNT_W-1:0]      r_inflight;

  logic [CNT_W-1:0]      w_count;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_push_last;
  logic                  w_flush;
  logic                  w_head_last;
  logic [AXI_DATA_W-1:0] w_head_data;
  logic [LEN_W-1:0]      w_bound;
  logic [LEN_W-1:0]      w_free;
  logic [LEN_W-1:0]      w_burst;

  assign w_push      = (r_state == ST_REQ) & databus_ready_i;
  assign w_push_last = databus_last_i & (r_row_rem == databus_len_o) & (r_rows == ROWS_W'(1));
  assign w_flush     = (r_state == ST_IDLE) & ~running_i;

  assign data_valid_o = ~w_empty;
  assign data_o       = w_head_data;
  assign data_last_o  = ~w_empty & w_head_last;

  // Burst size: smallest of row remainder, burst cap, bytes to 4 KiB boundary, and FIFO credit.
  always_comb begin
    w_bound = LEN_W'(BOUNDARY_BYTES) - LEN_W'(r_cur_addr[BOUNDARY_W-1:0]);
    w_free  = (LEN_W'(FIFO_DEPTH) - LEN_W'(w_count) - LEN_W'(r_inflight)) << LOG2_BPB;
    w_burst = r_row_rem;
    if (w_burst > LEN_W'(MAX_BYTES)) w_burst = LEN_W'(MAX_BYTES);
    if (w_burst > w_bound)           w_burst = w_bound;
    if (w_burst > w_free)            w_burst = w_free;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_rows          <= '0;
      r_row_base      <= '0;
      r_cur_addr      <= '0;
      r_shift         <= '0;
      r_row_rem       <= '0;
      r_length        <= '0;
      r_inflight      <= '0;
      done_o          <= 1'b1;
      databus_valid_o <= 1'b0;
      databus_addr_o  <= '0;
      databus_len_o   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run_i) begin
            r_rows     <= ROWS_W'(read_amount_minus_one_i) + ROWS_W'(1);
            r_row_base <= ext_addr_i;
            r_cur_addr <= ext_addr_i;
            r_shift    <= read_addr_shift_i;
            r_row_rem  <= read_length_i;
            r_length   <= read_length_i;
            done_o     <= 1'b0;
            r_state    <= ST_PLAN;
          end
        end
        ST_PLAN: begin
          if (r_rows == '0) begin
            r_state <= ST_DRAIN;
          end else if (r_row_rem == '0) begin
            r_rows     <= r_rows - ROWS_W'(1);
            r_row_base <= r_row_base + r_shift;
            r_cur_addr <= r_row_base + r_shift;
            r_row_rem  <= r_length;
          end else if (w_burst != '0) begin
            databus_valid_o <= 1'b1;
            databus_addr_o  <= r_cur_addr;
            databus_len_o   <= w_burst;
            r_inflight      <= CNT_W'(w_burst >> LOG2_BPB);
            r_state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (databus_ready_i) begin
            r_inflight <= r_inflight - CNT_W'(1);
            if (databus_last_i) begin
              r_cur_addr      <= r_cur_addr + AXI_ADDR_W'(databus_len_o);
              r_row_rem       <= r_row_rem - databus_len_o;
              databus_valid_o <= 1'b0;
              r_state         <= ST_PLAN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            done_o  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  burst_fifo #(
    .DATA_W (AXI_DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (databus_rdata_i),
    .i_last  (w_push_last),
    .i_pop   (data_ready_i),
    .o_data  (w_head_data),
    .o_last  (w_head_last),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule
